// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared widths, types and FSM encoding for the refill controller
package cache_refill_ctrl_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int BLOCK_SIZE    = 16;
  localparam int OFFSET_BITS   = 4;
  localparam int ADDR_WIDTH    = 32;
  localparam int BLOCK_BITS    = WORD_SIZE * BLOCK_SIZE;
  localparam int BLK_ADDR_BITS = ADDR_WIDTH - OFFSET_BITS;

  typedef logic [WORD_SIZE-1:0]     word_t;
  typedef logic [BLOCK_BITS-1:0]    block_t;
  typedef logic [ADDR_WIDTH-1:0]    addr_t;
  typedef logic [OFFSET_BITS-1:0]   offset_t;
  typedef logic [BLK_ADDR_BITS-1:0] blk_addr_t;

  localparam offset_t LAST_OFFSET = offset_t'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - cache request/response and data-memory transaction signals
// master: cache + memory side; slave: the refill controller.
interface cache_refill_ctrl_if
  import cache_refill_ctrl_pkg::*;
();
  logic   req_valid;
  logic   req_ready;
  logic   req_wb;
  addr_t  req_wb_addr;
  block_t req_wb_block;
  addr_t  req_fill_addr;
  logic   resp_valid;
  block_t resp_block;
  logic   mem_req;
  logic   mem_we;
  addr_t  mem_addr;
  word_t  mem_wdata;
  logic   mem_gnt;
  logic   mem_rvalid;
  word_t  mem_rdata;

  modport master (
    output req_valid, req_wb, req_wb_addr, req_wb_block, req_fill_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_block, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wb, req_wb_addr, req_wb_block, req_fill_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_block, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_refill_ctrl_refill_block_assembler.sv
// rtl/cache_refill_ctrl_refill_block_assembler.sv - collects in-order fill words into one block
// Words shift in at the LSB end, so the first word received ends up at the MSB (offset 0).
module refill_block_assembler
  import cache_refill_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   in_valid,
  input  word_t  in_data,
  output block_t block,
  output logic   last_beat
);

  offset_t rx_count;
  logic    full;

  assign last_beat = in_valid && !full && (rx_count == LAST_OFFSET);

  always_ff @(posedge clk) begin
    if (reset) begin
      block    <= '0;
      rx_count <= '0;
      full     <= 1'b0;
    end else if (clear) begin
      rx_count <= '0;
      full     <= 1'b0;
    end else if (in_valid && !full) begin
      block    <= {block[BLOCK_BITS-WORD_SIZE-1:0], in_data};
      rx_count <= rx_count + offset_t'(1);
      if (rx_count == LAST_OFFSET) full <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - miss handler: optional victim write-back, then 16-word block fill
// Optional perf counters are built when CACHE_REFILL_PERF_EN is defined.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic reset,
  cache_refill_ctrl_if.slave bus
`ifdef CACHE_REFILL_PERF_EN
  ,
  output logic [31:0] perf_fills,
  output logic [31:0] perf_wbs,
  output logic [31:0] perf_busy_cycles
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  typedef logic [OUT_W-1:0] out_cnt_t;
  localparam out_cnt_t MAX_OUT = out_cnt_t'(MAX_OUTSTANDING);

  refill_state_e state;
  offset_t       offset, offset_inc;
  out_cnt_t      outstanding, out_nx;
  logic          issued_all, issued_nx;
  blk_addr_t     wb_blk, fill_blk;
  block_t        wb_shift, asm_block;
  logic          accept, gnt, rv, asm_last;
  logic          unused_offset_bits;

  assign unused_offset_bits = ^{bus.req_wb_addr[OFFSET_BITS-1:0], bus.req_fill_addr[OFFSET_BITS-1:0]};

  assign accept     = (state == ST_IDLE) && bus.req_ready && bus.req_valid;
  assign gnt        = bus.mem_req && bus.mem_gnt;
  assign rv         = (state == ST_FILL) && bus.mem_rvalid && (outstanding != '0);
  assign offset_inc = offset + offset_t'(1);
  // Issue offset wraps after the last read, so completion is tracked by a sticky flag.
  assign issued_nx  = issued_all || ((state == ST_FILL) && gnt && (offset == LAST_OFFSET));

  always_comb begin
    out_nx = outstanding;
    if ((state == ST_FILL) && gnt) out_nx = out_nx + out_cnt_t'(1);
    if (rv) out_nx = out_nx - out_cnt_t'(1);
  end

  refill_block_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .in_valid  (rv),
    .in_data   (bus.mem_rdata),
    .block     (asm_block),
    .last_beat (asm_last)
  );

  assign bus.resp_block = asm_block;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.req_ready <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      offset        <= '0;
      outstanding   <= '0;
      issued_all    <= 1'b0;
      wb_blk        <= '0;
      fill_blk      <= '0;
      wb_shift      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bus.req_ready <= 1'b0;
            wb_blk        <= bus.req_wb_addr[ADDR_WIDTH-1:OFFSET_BITS];
            fill_blk      <= bus.req_fill_addr[ADDR_WIDTH-1:OFFSET_BITS];
            offset        <= '0;
            outstanding   <= '0;
            issued_all    <= 1'b0;
            bus.mem_req   <= 1'b1;
            if (bus.req_wb) begin
              state         <= ST_WB;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {bus.req_wb_addr[ADDR_WIDTH-1:OFFSET_BITS], offset_t'(0)};
              bus.mem_wdata <= bus.req_wb_block[BLOCK_BITS-1 -: WORD_SIZE];
              wb_shift      <= bus.req_wb_block << WORD_SIZE;
            end else begin
              state        <= ST_FILL;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= {bus.req_fill_addr[ADDR_WIDTH-1:OFFSET_BITS], offset_t'(0)};
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        ST_WB: begin
          if (gnt) begin
            if (offset == LAST_OFFSET) begin
              state        <= ST_FILL;
              offset       <= '0;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= {fill_blk, offset_t'(0)};
            end else begin
              offset        <= offset_inc;
              bus.mem_addr  <= {wb_blk, offset_inc};
              bus.mem_wdata <= wb_shift[BLOCK_BITS-1 -: WORD_SIZE];
              wb_shift      <= wb_shift << WORD_SIZE;
            end
          end
        end
        ST_FILL: begin
          outstanding  <= out_nx;
          issued_all   <= issued_nx;
          if (gnt) offset <= offset_inc;
          bus.mem_addr <= {fill_blk, gnt ? offset_inc : offset};
          bus.mem_req  <= !issued_nx && (out_nx < MAX_OUT);
          if (asm_last) begin
            state          <= ST_DONE;
            bus.resp_valid <= 1'b1;
            bus.mem_req    <= 1'b0;
          end
        end
        ST_DONE: begin
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CACHE_REFILL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fills       <= '0;
      perf_wbs         <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if ((state != ST_IDLE) && (perf_busy_cycles != '1)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if ((state == ST_DONE) && (perf_fills != '1)) perf_fills <= perf_fills + 32'd1;
      if ((state == ST_WB) && gnt && (offset == LAST_OFFSET) && (perf_wbs != '1))
        perf_wbs <= perf_wbs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench: vector table, corner sequences, random requests
// Perf counter checks are compiled in when CACHE_REFILL_PERF_EN is defined.
module tb_cache_refill_ctrl;
  import cache_refill_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_refill_ctrl_if bus();
`ifdef CACHE_REFILL_PERF_EN
  logic [31:0] perf_fills, perf_wbs, perf_busy_cycles;
`endif

  cache_refill_ctrl #(.MAX_OUTSTANDING(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CACHE_REFILL_PERF_EN
    ,
    .perf_fills       (perf_fills),
    .perf_wbs         (perf_wbs),
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } tx_t;
  typedef struct { int unsigned due; logic [31:0] data; } rd_t;
  typedef struct {
    bit wb; logic [31:0] wa; logic [31:0] fa; int gm; int rl; int lat;
    logic [31:0] msb; logic [31:0] lsb;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int unsigned ncyc = 0;
  tx_t obs_q[$];
  tx_t exp_q[$];
  rd_t rd_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [511:0] exp_blk;
  int gnt_mode = 0;
  int rlat = 1;
  bit spur_rv = 0;
  bit gnt_phase = 0;
  int out_cnt = 0;
  int max_out = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(logic [511:0] b, int k);
    return b[(15-k)*32 +: 32];
  endfunction

  // Data memory: decides grant/return at each negedge; transaction commits at the next posedge.
  initial begin
    tx_t t;
    rd_t r;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_q.delete(); out_cnt = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0;
      end else begin
        bus.mem_rvalid = 0;
        if (rd_q.size() > 0 && rd_q[0].due <= ncyc) begin
          r = rd_q.pop_front();
          bus.mem_rvalid = 1; bus.mem_rdata = r.data; out_cnt--;
        end else if (spur_rv) begin
          bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        end
        case (gnt_mode)
          0: bus.mem_gnt = 1;
          1: begin gnt_phase = !gnt_phase; bus.mem_gnt = gnt_phase; end
          default: bus.mem_gnt = ($urandom_range(0, 3) != 0);
        endcase
        if (bus.mem_req && bus.mem_gnt) begin
          t.we = bus.mem_we; t.addr = bus.mem_addr; t.data = bus.mem_we ? bus.mem_wdata : 32'h0;
          obs_q.push_back(t);
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else begin
            r.due = ncyc + rlat;
            r.data = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : bus.mem_addr + 32'h1000;
            rd_q.push_back(r);
            out_cnt++;
            if (out_cnt > max_out) max_out = out_cnt;
          end
        end
      end
    end
  end

  // Reference: write-back lands in full before the fill reads; fill word k sits at offset k.
  task automatic model_req(bit wb, logic [31:0] wa, logic [511:0] wblk, logic [31:0] fa);
    tx_t t;
    logic [31:0] a;
    exp_q.delete();
    exp_blk = '0;
    if (wb) for (int k = 0; k < 16; k++) begin
      a = (wa & ~32'hF) + k;
      ref_mem[a] = word_of(wblk, k);
      t.we = 1; t.addr = a; t.data = word_of(wblk, k);
      exp_q.push_back(t);
    end
    for (int k = 0; k < 16; k++) begin
      a = (fa & ~32'hF) + k;
      t.we = 0; t.addr = a; t.data = 0;
      exp_q.push_back(t);
      exp_blk[(15-k)*32 +: 32] = ref_mem.exists(a) ? ref_mem[a] : a + 32'h1000;
    end
  endtask

  task automatic start_req(bit wb, logic [31:0] wa, logic [511:0] wblk, logic [31:0] fa,
                           output int unsigned acc, output bit ok);
    ok = 0; acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    chk("req_ready_wait", ok, 1);
    if (!ok) return;
    bus.req_wb = wb; bus.req_wb_addr = wa; bus.req_wb_block = wblk; bus.req_fill_addr = fa;
    bus.req_valid = 1;
    acc = ncyc;
    obs_q.delete(); max_out = 0;
    model_req(wb, wa, wblk, fa);
  endtask

  task automatic finish_req(bit hold, int unsigned acc, int exp_lat, string tag,
                            output logic [511:0] rblk);
    bit got = 0;
    int unsigned lat;
    int n;
    rblk = '0;
    @(negedge clk);
    if (hold) begin
      bus.req_fill_addr = ~bus.req_fill_addr; bus.req_wb_addr = ~bus.req_wb_addr;
    end else bus.req_valid = 0;
    chk({tag, ".ready_drop"}, bus.req_ready, 0);
    for (int i = 0; i < 3000; i++) begin
      if (bus.resp_valid) begin got = 1; break; end
      @(negedge clk);
    end
    bus.req_valid = 0;
    chk({tag, ".resp_seen"}, got, 1);
    if (!got) return;
    lat = ncyc - acc;
    rblk = bus.resp_block;
    if (exp_lat >= 0) chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".block"}, rblk, exp_blk);
    chk({tag, ".tx_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.tx%0d", tag, i), {obs_q[i].we, obs_q[i].addr, obs_q[i].data},
          {exp_q[i].we, exp_q[i].addr, exp_q[i].data});
    chk({tag, ".outstanding_le_4"}, (max_out <= 4), 1);
    @(negedge clk);
    chk({tag, ".resp_one_cycle"}, bus.resp_valid, 0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, ".req_ready"}, bus.req_ready, 0);
    chk({tag, ".resp_valid"}, bus.resp_valid, 0);
    chk({tag, ".resp_block"}, bus.resp_block, 0);
    chk({tag, ".mem_req"}, bus.mem_req, 0);
    chk({tag, ".mem_we"}, bus.mem_we, 0);
    chk({tag, ".mem_addr"}, bus.mem_addr, 0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    vec_t vecs[4];
    logic [511:0] blk, rblk, rnd;
    int unsigned acc;
    bit ok, saw, wb;
    logic [31:0] wa, fa;
    int gm, rl;

    bus.req_valid = 0; bus.req_wb = 0; bus.req_wb_addr = 0; bus.req_wb_block = 0;
    bus.req_fill_addr = 0;
    vecs[0] = '{0, 32'h0,   32'h123, 0, 1, 18, 32'h1120, 32'h112F};
    vecs[1] = '{1, 32'h450, 32'h9A7, 0, 1, 34, 32'h19A0, 32'h19AF};
    vecs[2] = '{0, 32'h0,   32'h3C0, 1, 5, -1, 32'h13C0, 32'h13CF};
    vecs[3] = '{1, 32'h800, 32'h800, 0, 1, 34, 32'hA0,   32'hAF};
    for (int k = 0; k < 16; k++) blk[(15-k)*32 +: 32] = 32'hA0 + k;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", bus.req_ready, 1);

    // Reset ten cycles into a write-back: request abandoned, no response, clean restart.
    start_req(1, 32'hF000, blk, 32'hF100, acc, ok);
    @(negedge clk);
    bus.req_valid = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_reset_outputs("mid_wb_reset");
    reset = 0;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.resp_valid) saw = 1;
    end
    chk("no_resp_after_reset", saw, 0);

    for (int i = 0; i < 4; i++) begin
      gnt_mode = vecs[i].gm; rlat = vecs[i].rl;
      start_req(vecs[i].wb, vecs[i].wa, blk, vecs[i].fa, acc, ok);
      if (ok) begin
        finish_req(0, acc, vecs[i].lat, $sformatf("vec%0d", i), rblk);
        chk($sformatf("vec%0d.msb_word", i), word_of(rblk, 0), vecs[i].msb);
        chk($sformatf("vec%0d.lsb_word", i), word_of(rblk, 15), vecs[i].lsb);
      end
`ifdef CACHE_REFILL_PERF_EN
      if (i == 1) begin
        chk("perf_fills", perf_fills, 2);
        chk("perf_wbs", perf_wbs, 1);
        chk("perf_busy_cycles", perf_busy_cycles, 52);
      end
`endif
    end

    // Stray read returns while idle must not disturb the next fill.
    gnt_mode = 0; rlat = 1;
    spur_rv = 1;
    repeat (5) @(negedge clk);
    spur_rv = 0;
    start_req(0, 32'h0, blk, 32'h2345, acc, ok);
    if (ok) finish_req(0, acc, 18, "spurious_rvalid", rblk);

    // req_valid held with changing inputs while busy: ignored, latched request unaffected.
    gnt_mode = 2; rlat = 3;
    start_req(1, 32'h1230, blk, 32'h1240, acc, ok);
    if (ok) finish_req(1, acc, -1, "hold_valid", rblk);

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 16; k++) rnd[(15-k)*32 +: 32] = $urandom();
      wb = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 32'h7FFF);
      fa = ($urandom_range(0, 3) == 0) ? ((wa & ~32'hF) | $urandom_range(0, 15))
                                        : $urandom_range(0, 32'h7FFF);
      gm = $urandom_range(0, 2);
      rl = $urandom_range(1, 6);
      gnt_mode = gm; rlat = rl;
      start_req(wb, wa, rnd, fa, acc, ok);
      if (ok) finish_req(0, acc, (gm == 0 && rl == 1) ? (wb ? 34 : 18) : -1,
                         $sformatf("rand%0d", n), rblk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
